// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter
//   Owns the single-port instruction RAM and shares it between the CPU fetch
//   path and a byte-stream program loader. While a load runs, the CPU is
//   stalled and fed NOPs. Received words are written from index 0 upward.
//   When the load finishes, cpu_restart pulses so the pipeline refetches
//   from PC 0.
//
//   Stream format: a 16-bit big-endian word count, then 4 big-endian bytes
//   per word.
//
//   Ports
//     clk, reset              clock, synchronous active-high reset
//     cpu_addr / cpu_instr    fetch byte address in, instruction out (NOP while stalled)
//     cpu_stall, cpu_restart  hold the fetch path; one-cycle refetch pulse after a load
//     ld_start                pulse that starts a load session (IDLE only)
//     ld_valid/ld_ready/ld_byte  byte handshake from the loader
//     ld_err                  sticky: header word count exceeded DEPTH
//     mem_addr/mem_wdata/mem_we/mem_rdata  RAM port (read data is combinational)
//
//   state | meaning
//   IDLE  | CPU owns the RAM, fetch is a zero-cycle read
//   HDR0  | waiting for the count high byte
//   HDR1  | waiting for the count low byte
//   DATA  | shifting 4 bytes into the word register
//   WRITE | one-cycle RAM write of the assembled word
//   DONE  | one-cycle cpu_restart pulse, then back to IDLE
module imem_load_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       cpu_addr,
   output logic [31:0]       cpu_instr,
   output logic              cpu_stall,
   output logic              cpu_restart,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   output logic              ld_ready,
   output logic              ld_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [16:0]      DEPTH_C = 17'(DEPTH);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE} state_t;

   state_t           state, state_nx;
   logic [7:0]       cnt_hi;
   logic [15:0]      words_left;
   logic [PTR_W-1:0] wr_ptr;
   logic [1:0]       byte_cnt;
   logic [31:0]      word;
   logic             xfer;
   logic             unused_ok;

   // Only the word-index bits of the PC reach the RAM.
   assign unused_ok = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

   assign xfer = ld_valid & ld_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt_hi     <= '0;
         words_left <= '0;
         wr_ptr     <= '0;
         byte_cnt   <= '0;
         word       <= '0;
         ld_err     <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (ld_start) ld_err <= 1'b0;
            HDR0: if (xfer) cnt_hi <= ld_byte;
            HDR1: if (xfer) begin
               words_left <= {cnt_hi, ld_byte};
               if ({1'b0, cnt_hi, ld_byte} > DEPTH_C) ld_err <= 1'b1;
            end
            DATA: if (xfer) begin
               word     <= {word[23:0], ld_byte};
               byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 on the 4th byte
            end
            WRITE: begin
               // Pointer parks at DEPTH so excess words are consumed but never written.
               if (wr_ptr < DEPTH_P) wr_ptr <= wr_ptr + 1'b1;
               words_left <= words_left - 16'd1;
            end
            DONE: begin
               wr_ptr   <= '0;
               byte_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (ld_start) state_nx = HDR0;
         HDR0:  if (xfer) state_nx = HDR1;
         HDR1:  if (xfer) state_nx = ({cnt_hi, ld_byte} == 16'd0) ? DONE : DATA;
         DATA:  if (xfer && byte_cnt == 2'd3) state_nx = WRITE;
         WRITE: state_nx = (words_left == 16'd1) ? DONE : DATA;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      cpu_stall   = (state != IDLE);
      cpu_restart = (state == DONE);
      cpu_instr   = 32'h0;
      mem_addr    = wr_ptr[ADDR_W-1:0];
      mem_wdata   = word;
      mem_we      = (state == WRITE) && (wr_ptr < DEPTH_P);
      ld_ready    = (state == HDR0) || (state == HDR1) || (state == DATA);
      if (state == IDLE) begin
         mem_addr  = cpu_addr[ADDR_W+1:2];
         cpu_instr = mem_rdata;
      end
   end

endmodule

// File: tb/tb_imem_load_arbiter.sv
module tb_imem_load_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] cpu_addr = 32'h0;
   logic [31:0] cpu_instr;
   logic        cpu_stall, cpu_restart;
   logic        ld_start = 1'b0, ld_valid = 1'b0;
   logic [7:0]  ld_byte = 8'h0;
   logic        ld_ready, ld_err;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_we;

   logic [31:0] ram [256];
   logic        preset_en = 1'b0;
   logic [7:0]  preset_addr = 8'h0;
   logic [31:0] preset_data = 32'h0;
   int          n_wr = 0, n_hi = 0, n_rst = 0;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   imem_load_arbiter #(.ADDR_W(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_instr(cpu_instr),
      .cpu_stall(cpu_stall), .cpu_restart(cpu_restart),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
      .ld_ready(ld_ready), .ld_err(ld_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   assign mem_rdata = ram[mem_addr];

   always @(posedge clk) begin
      if (preset_en) ram[preset_addr] <= preset_data;
      if (mem_we === 1'b1) begin
         ram[mem_addr] <= mem_wdata;
         n_wr <= n_wr + 1;
         if (mem_addr >= 8'd4) n_hi <= n_hi + 1;
      end
      if (cpu_restart === 1'b1) n_rst <= n_rst + 1;
   end

   typedef struct {
      logic       start;
      logic       valid;
      logic [7:0] b;
      logic [4:0] exp;   // {stall, restart, ready, we, err}
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      ld_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         #1;
         chk("gap_ready", {31'b0, ld_ready}, 32'd1);
         tick();
      end
      ld_valid = 1'b1;
      ld_byte  = b;
      #1;
      w = 0;
      while (ld_ready !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      chk("byte_ready", {31'b0, ld_ready}, 32'd1);
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic wait_restart();
      int w;
      w = 0;
      #1;
      while (cpu_restart !== 1'b1 && w < 40) begin
         tick();
         w++;
      end
      chk("restart_seen", {31'b0, cpu_restart}, 32'd1);
   endtask

   initial begin
      int wr0, rst0;
      logic [31:0] wd;

      // Test 1 cycle table; row 0 offers a byte with ld_start (must be dropped),
      // row 7 offers a byte during WRITE (must be held until DATA).
      vecs[0]  = '{1'b1, 1'b1, 8'hAA, 5'b00000};
      vecs[1]  = '{1'b0, 1'b1, 8'h00, 5'b10100};
      vecs[2]  = '{1'b0, 1'b1, 8'h02, 5'b10100};
      vecs[3]  = '{1'b0, 1'b1, 8'h20, 5'b10100};
      vecs[4]  = '{1'b0, 1'b1, 8'h12, 5'b10100};
      vecs[5]  = '{1'b0, 1'b1, 8'h00, 5'b10100};
      vecs[6]  = '{1'b0, 1'b1, 8'h0A, 5'b10100};
      vecs[7]  = '{1'b0, 1'b1, 8'h20, 5'b10010};
      vecs[8]  = '{1'b0, 1'b1, 8'h20, 5'b10100};
      vecs[9]  = '{1'b0, 1'b1, 8'h13, 5'b10100};
      vecs[10] = '{1'b0, 1'b1, 8'h00, 5'b10100};
      vecs[11] = '{1'b0, 1'b1, 8'h0A, 5'b10100};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 5'b10010};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 5'b11000};
      vecs[14] = '{1'b0, 1'b0, 8'h00, 5'b00000};

      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("reset_outputs", {27'b0, cpu_stall, cpu_restart, ld_ready, mem_we, ld_err}, 32'd0);

      // Test 1: two-word load, cycle by cycle
      wr0 = n_wr; rst0 = n_rst;
      for (int i = 0; i < 15; i++) begin
         ld_start = vecs[i].start;
         ld_valid = vecs[i].valid;
         ld_byte  = vecs[i].b;
         #1;
         chk($sformatf("t1_row%0d", i),
             {27'b0, cpu_stall, cpu_restart, ld_ready, mem_we, ld_err},
             {27'b0, vecs[i].exp});
         if (vecs[i].exp[4]) chk($sformatf("t1_nop%0d", i), cpu_instr, 32'h0);
         tick();
      end
      chk("t1_ram0", ram[0], 32'h2012000A);
      chk("t1_ram1", ram[1], 32'h2013000A);
      chk("t1_writes", n_wr - wr0, 32'd2);
      chk("t1_restarts", n_rst - rst0, 32'd1);

      // Test 2: zero-cycle fetch in IDLE
      preset_en = 1'b1; preset_addr = 8'd2; preset_data = 32'h20140000;
      tick();
      preset_en = 1'b0;
      cpu_addr = 32'h8;
      #1;
      chk("t2_instr", cpu_instr, 32'h20140000);
      chk("t2_memaddr", {24'b0, mem_addr}, 32'd2);
      chk("t2_stall", {31'b0, cpu_stall}, 32'd0);
      cpu_addr = 32'h4;
      #1;
      chk("t2_instr_b", cpu_instr, 32'h2013000A);
      tick();

      // Test 3: empty load goes HDR1 -> DONE
      wr0 = n_wr; rst0 = n_rst;
      start_load();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      #1;
      chk("t3_restart", {31'b0, cpu_restart}, 32'd1);
      chk("t3_stall_done", {31'b0, cpu_stall}, 32'd1);
      tick();
      chk("t3_stall_idle", {31'b0, cpu_stall}, 32'd0);
      tick();
      chk("t3_writes", n_wr - wr0, 32'd0);
      chk("t3_restarts", n_rst - rst0, 32'd1);

      // Test 4: 3-cycle ld_valid gap after byte 2
      rst0 = n_rst;
      start_load();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      send_byte(8'hBE, 3);
      send_byte(8'hEF, 0);
      wait_restart();
      tick();
      tick();
      chk("t4_ram0", ram[0], 32'hDEADBEEF);
      chk("t4_err", {31'b0, ld_err}, 32'd0);
      chk("t4_restarts", n_rst - rst0, 32'd1);

      // Test 5: count 5 with DEPTH 4 -> error, only 0..3 written
      wr0 = n_wr; rst0 = n_rst;
      start_load();
      send_byte(8'h00, 0);
      send_byte(8'h05, 0);
      #1;
      chk("t5_err_set", {31'b0, ld_err}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         wd = 32'hA0B0C000 + 32'(k);
         for (int j = 0; j < 4; j++) begin
            send_byte(wd[31-8*j -: 8], 0);
         end
      end
      wait_restart();
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t5_ram%0d", k), ram[k], 32'hA0B0C000 + 32'(k));
      end
      chk("t5_writes", n_wr - wr0, 32'd4);
      chk("t5_high_writes", n_hi, 32'd0);
      chk("t5_restarts", n_rst - rst0, 32'd1);
      chk("t5_err_sticky", {31'b0, ld_err}, 32'd1);

      // Test 6: reset mid-word, ld_start ignored during DATA
      rst0 = n_rst;
      start_load();
      #1;
      chk("t6_err_cleared", {31'b0, ld_err}, 32'd0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      send_byte(8'h05, 0);
      send_byte(8'h06, 0);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      #1;
      chk("t6_start_ignored_stall", {31'b0, cpu_stall}, 32'd1);
      chk("t6_start_ignored_ready", {31'b0, ld_ready}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cpu_addr = 32'h0;
      #1;
      chk("t6_stall", {31'b0, cpu_stall}, 32'd0);
      chk("t6_ready", {31'b0, ld_ready}, 32'd0);
      chk("t6_word0", cpu_instr, 32'h01020304);
      tick();
      tick();
      chk("t6_restarts", n_rst - rst0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
